// File: rtl/genius_pkg.sv
// Shared types and helpers for the genius game and its autoplayer.
// Contents:
//   color_t            - one LED / button colour, one-hot when valid
//   autoplayer_state_t - autoplayer FSM states
//   is_onehot()        - true when exactly one bit of a colour is set
//   rotl_color()       - rotate a colour left by one position (wraps)
package genius_pkg;

  typedef logic [3:0] color_t;

  typedef enum logic [3:0] {
    IDLE,
    START,
    WAIT_ON,
    WAIT_OFF,
    SETTLE,
    PRESS,
    GAP,
    VERIFY,
    WIN,
    FAIL
  } autoplayer_state_t;

  function automatic logic is_onehot(color_t c);
    // Clearing the lowest set bit leaves zero only for a single-bit value.
    return (c != 4'd0) && ((c & (c - 4'd1)) == 4'd0);
  endfunction

  function automatic color_t rotl_color(color_t c);
    return {c[2:0], c[3]};
  endfunction

endpackage

// File: rtl/genius_autoplayer_if.sv
// Game-side connection between the autoplayer and the genius game.
// Signals:
//   leds   - colour currently shown by the game (game -> player)
//   score  - game score (game -> player)
//   start  - one-cycle start pulse (player -> game)
//   buttom - button drive (player -> game)
// Modports:
//   master - the autoplayer side
//   slave  - the game side
interface genius_autoplayer_if;
  import genius_pkg::*;

  color_t      leds;
  logic [5:0]  score;
  logic        start;
  color_t      buttom;

  modport master (
    input  leds,
    input  score,
    output start,
    output buttom
  );

  modport slave (
    output leds,
    output score,
    input  start,
    input  buttom
  );

endinterface

// File: rtl/genius_seq_mem.sv
// Capture buffer for the colour sequence shown by the game.
// DEPTH x 4-bit register file with one synchronous write port and one
// combinational read port. Contents are not reset; every entry that is
// read in a round has been written earlier in that round.
// Ports:
//   clk   - clock
//   we    - write enable
//   waddr - write address
//   wdata - colour to store
//   raddr - read address
//   rdata - colour at raddr (combinational)
module genius_seq_mem
  import genius_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  color_t        wdata,
  input  logic [AW-1:0] raddr,
  output color_t        rdata
);

  color_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/genius_autoplayer.sv
// Hardware player for the genius game.
// Each round it records the colours the game shows, waits for the game to
// go quiet, replays the colours as timed button presses and then checks
// that the score advanced to the round number. A session optionally
// corrupts the first press of the final round to exercise game-over.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   go             - one-cycle session start request (ignored while busy)
//   target_rounds  - rounds to win (0 -> 1, clamped to MAX_SEQ)
//   inject_err     - sampled with go; corrupts one press of the last round
//   game           - game connection (leds/score in, start/buttom out)
//   round          - current 1-based round, 0 after reset
//   busy           - session in progress
//   win, fail      - sticky session results
module genius_autoplayer
  import genius_pkg::*;
#(
  parameter int MAX_SEQ       = 32,
  parameter int PRESS_CYCLES  = 4,
  parameter int GAP_CYCLES    = 5,
  parameter int SETTLE_CYCLES = 20,
  parameter int VERIFY_CYCLES = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                go,
  input  logic [5:0]          target_rounds,
  input  logic                inject_err,
  genius_autoplayer_if.master game,
  output logic [5:0]          round,
  output logic                busy,
  output logic                win,
  output logic                fail
);

  localparam int RW     = $clog2(MAX_SEQ) + 1;
  localparam int AW     = (MAX_SEQ > 1) ? $clog2(MAX_SEQ) : 1;
  localparam int MAXC_A = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int MAXC_B = (SETTLE_CYCLES > VERIFY_CYCLES) ? SETTLE_CYCLES : VERIFY_CYCLES;
  localparam int MAXC   = (MAXC_A > MAXC_B) ? MAXC_A : MAXC_B;
  localparam int TW     = $clog2(MAXC + 1);

  autoplayer_state_t state_q, state_d;
  logic [RW-1:0]     round_q, round_d;
  logic [RW-1:0]     target_q, target_d;
  logic              inj_q, inj_d;
  logic [RW-1:0]     wr_idx_q, wr_idx_d;
  logic [RW-1:0]     rd_idx_q, rd_idx_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic              win_q, win_d;
  logic              fail_q, fail_d;

  logic              mem_we;
  color_t            mem_rdata;
  color_t            press_color;

  function automatic logic [RW-1:0] clamp_target(logic [5:0] t);
    if (t == 6'd0) begin
      return RW'(1);
    end else if (int'(t) > MAX_SEQ) begin
      return RW'(MAX_SEQ);
    end else begin
      return RW'(t);
    end
  endfunction

  genius_seq_mem #(
    .DEPTH (MAX_SEQ),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_idx_q[AW-1:0]),
    .wdata (game.leds),
    .raddr (rd_idx_q[AW-1:0]),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      round_q  <= '0;
      target_q <= '0;
      inj_q    <= 1'b0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      cnt_q    <= '0;
      win_q    <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      target_q <= target_d;
      inj_q    <= inj_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      fail_q   <= fail_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    target_d = target_q;
    inj_d    = inj_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    fail_d   = fail_q;
    mem_we   = 1'b0;

    case (state_q)
      // Terminal states accept go exactly like IDLE.
      IDLE, WIN, FAIL: begin
        if (go) begin
          target_d = clamp_target(target_rounds);
          inj_d    = inject_err;
          win_d    = 1'b0;
          fail_d   = 1'b0;
          round_d  = RW'(1);
          state_d  = START;
        end
      end

      START: begin
        wr_idx_d = '0;
        state_d  = WAIT_ON;
      end

      WAIT_ON: begin
        if (game.leds != 4'd0) begin
          if (!is_onehot(game.leds) || (wr_idx_q >= RW'(MAX_SEQ))) begin
            fail_d  = 1'b1;
            state_d = FAIL;
          end else begin
            mem_we  = 1'b1;
            state_d = WAIT_OFF;
          end
        end
      end

      // Only the falling edge of a colour advances the index, so a colour
      // held for many cycles is recorded once.
      WAIT_OFF: begin
        if (game.leds == 4'd0) begin
          if (wr_idx_q < RW'(MAX_SEQ)) begin
            wr_idx_d = wr_idx_q + RW'(1);
          end
          if ((wr_idx_q + RW'(1)) == round_q) begin
            cnt_d   = '0;
            state_d = SETTLE;
          end else begin
            state_d = WAIT_ON;
          end
        end
      end

      // Any colour during the quiet window means the game showed more
      // colours than this round should contain.
      SETTLE: begin
        if (game.leds != 4'd0) begin
          fail_d  = 1'b1;
          state_d = FAIL;
        end else if (cnt_q >= TW'(SETTLE_CYCLES - 1)) begin
          cnt_d    = '0;
          rd_idx_d = '0;
          state_d  = PRESS;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end

      PRESS: begin
        if (cnt_q >= TW'(PRESS_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end

      GAP: begin
        if (cnt_q >= TW'(GAP_CYCLES - 1)) begin
          cnt_d = '0;
          if (rd_idx_q < RW'(MAX_SEQ)) begin
            rd_idx_d = rd_idx_q + RW'(1);
          end
          if ((rd_idx_q + RW'(1)) == round_q) begin
            state_d = VERIFY;
          end else begin
            state_d = PRESS;
          end
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end

      VERIFY: begin
        if (cnt_q >= TW'(VERIFY_CYCLES)) begin
          cnt_d = '0;
          if (game.score == 6'(round_q)) begin
            if (round_q == target_q) begin
              win_d   = 1'b1;
              state_d = WIN;
            end else begin
              round_d  = round_q + RW'(1);
              wr_idx_d = '0;
              state_d  = WAIT_ON;
            end
          end else if (inj_q && (game.score == 6'd0)) begin
            // The corrupted press made the game reset its score: that is
            // the outcome an injected-error session is looking for.
            win_d   = 1'b1;
            state_d = WIN;
          end else begin
            fail_d  = 1'b1;
            state_d = FAIL;
          end
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The first press of the final round is rotated when an error is armed.
  assign press_color = (inj_q && (round_q == target_q) && (rd_idx_q == '0))
                       ? rotl_color(mem_rdata) : mem_rdata;

  // Decoded straight from the state register so reset clears it at once.
  assign game.buttom = (state_q == PRESS) ? press_color : 4'd0;
  assign game.start  = (state_q == START);

  assign round = 6'(round_q);
  assign busy  = (state_q != IDLE) && (state_q != WIN) && (state_q != FAIL);
  assign win   = win_q;
  assign fail  = fail_q;

endmodule

// File: tb/tb_genius_autoplayer.sv
module tb_genius_autoplayer;
  import genius_pkg::*;

  localparam int MAX_SEQ       = 32;
  localparam int PRESS_CYCLES  = 4;
  localparam int GAP_CYCLES    = 5;
  localparam int SETTLE_CYCLES = 20;
  localparam int VERIFY_CYCLES = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       go = 1'b0;
  logic [5:0] target_rounds = 6'd0;
  logic       inject_err = 1'b0;
  logic [5:0] round;
  logic       busy;
  logic       win;
  logic       fail;

  genius_autoplayer_if gif();

  genius_autoplayer #(
    .MAX_SEQ       (MAX_SEQ),
    .PRESS_CYCLES  (PRESS_CYCLES),
    .GAP_CYCLES    (GAP_CYCLES),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .VERIFY_CYCLES (VERIFY_CYCLES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .go            (go),
    .target_rounds (target_rounds),
    .inject_err    (inject_err),
    .game          (gif),
    .round         (round),
    .busy          (busy),
    .win           (win),
    .fail          (fail)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic w;
    logic f;
    int   r;
  } end_t;

  logic [3:0] exp_press[$];
  end_t       exp_end[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [3:0] rand_color();
    logic [3:0] one;
    one = 4'b0001;
    return one << $urandom_range(0, 3);
  endfunction

  // Left rotation of a one-hot colour, by arithmetic: doubling, with 16 wrapping to 1.
  function automatic logic [3:0] rot_expected(input logic [3:0] c);
    int v;
    v = int'(c) * 2;
    if (v > 15) v = v - 15;
    return 4'(v);
  endfunction

  task automatic wait_btn(input bit nonzero, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if ((gif.buttom != 4'd0) == nonzero) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) timeout_fail(nonzero ? "wait_press" : "wait_release");
  endtask

  task automatic show_color(input logic [3:0] c, input int hold, input int gap);
    gif.leds = c;
    tick(hold);
    gif.leds = 4'd0;
    tick(gap);
  endtask

  // Behavioural game plus expectation generator.
  // mode 0: normal, 1: extra colour in round 2, 2: non-one-hot in round 1,
  // mode 3: round-1 colour 0100 held for 50 cycles.
  task automatic play_session(input int tgt, input bit inj, input int mode);
    int         eff;
    int         nr;
    bit         ok;
    bit         over;
    bit         wrong;
    bit         started;
    logic [3:0] c;
    logic [3:0] seq[$];

    eff = (tgt == 0) ? 1 : ((tgt > MAX_SEQ) ? MAX_SEQ : tgt);
    case (mode)
      1:       exp_end.push_back('{w: 1'b0, f: 1'b1, r: 2});
      2:       exp_end.push_back('{w: 1'b0, f: 1'b1, r: 1});
      default: exp_end.push_back('{w: 1'b1, f: 1'b0, r: eff});
    endcase

    tick();
    target_rounds = 6'(tgt);
    inject_err    = inj;
    go            = 1'b1;
    tick();
    go = 1'b0;
    started = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (gif.start) begin
        started = 1'b1;
        break;
      end
      tick();
    end
    if (!started) timeout_fail("start_pulse");
    chk("start_round", int'(round), 1);
    gif.score = 6'd0;
    tick();
    chk("start_one_cycle", int'(gif.start), 0);

    // A go while busy must not disturb the session.
    target_rounds = 6'd1;
    go = 1'b1;
    tick();
    go = 1'b0;
    tick(2);

    over = 1'b0;
    for (int r = 1; r <= eff; r++) begin
      if (mode == 3 && r == 1) seq.push_back(4'b0100);
      else seq.push_back(rand_color());
      if (mode == 2) begin
        gif.leds = 4'b0011;
        tick(3);
        gif.leds = 4'd0;
        break;
      end
      nr = (mode == 1 && r == 2) ? 3 : r;
      if (nr > r) seq.push_back(rand_color());
      for (int k = 0; k < nr; k++) begin
        show_color(seq[k], (mode == 3 && r == 1) ? 50 : int'($urandom_range(1, 4)),
                   int'($urandom_range(1, 3)));
      end
      if (mode == 1 && r == 2) break;

      for (int k = 0; k < r; k++) begin
        exp_press.push_back((inj && r == eff && k == 0) ? rot_expected(seq[0]) : seq[k]);
      end

      wrong = 1'b0;
      for (int k = 0; k < r; k++) begin
        wait_btn(1'b1, 200, ok);
        if (!ok) begin
          over = 1'b1;
          break;
        end
        c = gif.buttom;
        wait_btn(1'b0, 50, ok);
        if (c != seq[k]) wrong = 1'b1;
      end
      if (over) break;
      if (wrong) begin
        gif.score = 6'd0;
        break;
      end
      gif.score = 6'(r);
      if (r < eff) tick(25);
    end

    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) timeout_fail("session_end");
    tick(2);
  endtask

  // Monitor: measures every press and every session end and checks them
  // against the queued expectations.
  initial begin
    bit         in_press;
    bit         had_press;
    bit         prev_busy;
    int         plen;
    int         zrun;
    logic [3:0] pcol;
    logic [3:0] e;
    end_t       ee;
    in_press  = 1'b0;
    had_press = 1'b0;
    prev_busy = 1'b0;
    plen      = 0;
    zrun      = 0;
    pcol      = 4'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_press  = 1'b0;
        had_press = 1'b0;
        prev_busy = 1'b0;
        plen      = 0;
        zrun      = 0;
      end else begin
        if (gif.buttom != 4'd0) begin
          if (!in_press) begin
            if (had_press && zrun < SETTLE_CYCLES) chk("gap_len", zrun, GAP_CYCLES);
            in_press = 1'b1;
            plen     = 1;
            pcol     = gif.buttom;
          end else begin
            chk("press_stable", int'(gif.buttom), int'(pcol));
            plen++;
          end
        end else begin
          if (in_press) begin
            if (exp_press.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_press: got %b expected none", pcol);
            end else begin
              e = exp_press.pop_front();
              chk("press_color", int'(pcol), int'(e));
              chk("press_len", plen, PRESS_CYCLES);
              $display("press col=%b len=%0d", pcol, plen);
            end
            in_press  = 1'b0;
            had_press = 1'b1;
            zrun      = 1;
          end else if (zrun < 1000) begin
            zrun++;
          end
        end

        if (prev_busy && !busy) begin
          if (exp_end.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_end: got win=%0d fail=%0d expected no session", win, fail);
          end else begin
            ee = exp_end.pop_front();
            chk("end_win", int'(win), int'(ee.w));
            chk("end_fail", int'(fail), int'(ee.f));
            chk("end_round", int'(round), ee.r);
            chk("end_buttom", int'(gif.buttom), 0);
            chk("end_presses_left", exp_press.size(), 0);
            $display("session end win=%0d fail=%0d round=%0d", win, fail, round);
          end
          had_press = 1'b0;
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    #3000000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bit ok;
    gif.leds  = 4'd0;
    gif.score = 6'd0;
    rst_n = 1'b0;
    tick(3);
    chk("rst_round", int'(round), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_win", int'(win), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_start", int'(gif.start), 0);
    chk("rst_buttom", int'(gif.buttom), 0);
    rst_n = 1'b1;
    tick(2);

    play_session(3, 1'b0, 0);
    play_session(2, 1'b1, 0);
    play_session(3, 1'b0, 1);
    play_session(2, 1'b0, 2);
    play_session(2, 1'b0, 3);
    for (int i = 0; i < 3; i++) begin
      play_session(int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)), 0);
    end

    // Reset in the middle of a press.
    tick();
    target_rounds = 6'd3;
    inject_err    = 1'b0;
    go = 1'b1;
    tick();
    go = 1'b0;
    tick(3);
    show_color(4'b0010, 2, 2);
    wait_btn(1'b1, 100, ok);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_buttom", int'(gif.buttom), 0);
    chk("midrst_round", int'(round), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_win", int'(win), 0);
    chk("midrst_fail", int'(fail), 0);
    chk("midrst_start", int'(gif.start), 0);
    $display("reset during press: buttom=%b busy=%0d", gif.buttom, busy);
    exp_press.delete();
    tick(3);
    rst_n = 1'b1;
    tick(2);

    play_session(0, 1'b0, 0);
    play_session(40, 1'b0, 0);

    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/genius_autoplayer.md
Name: genius_autoplayer

Overview:
Hardware player for genius_fsm: drives its start/buttom inputs and watches its leds/score outputs. Each round it captures the colour sequence the game shows, waits for the game to enter input phase, and replays the sequence as timed button presses. It checks score after each round. Used for self-play regression and as the board demo "attract" mode. One optional injected mistake exercises the game-over path.

Parameters:
MAX_SEQ, 32, capture buffer depth and maximum playable round; round counters are $clog2(MAX_SEQ)+1 bits wide.
PRESS_CYCLES, 4, cycles buttom is held high per press.
GAP_CYCLES, 5, cycles buttom is held at zero after each press.
SETTLE_CYCLES, 20, cycles leds must stay zero after the last captured colour before replay starts.
VERIFY_CYCLES, 10, cycles waited after the last press before score is sampled.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
go  in  1  one-cycle pulse; starts a session when in IDLE.
target_rounds  in  6  rounds to win; value 0 is treated as 1; values above MAX_SEQ are clamped to MAX_SEQ.
inject_err  in  1  sampled at go; if 1, the first press of round target_rounds is corrupted.
leds  in  4  game LED output; colour is one-hot.
score  in  6  game score.
start  out  1  one-cycle start pulse to the game.
buttom  out  4  button drive to the game.
round  out  6  current round, 1-based; 0 when idle.
busy  out  1  high in every state except IDLE, WIN and FAIL.
win  out  1  sticky; set when target_rounds rounds pass.
fail  out  1  sticky; set on score mismatch, non-one-hot leds, or overflow.

Behaviour:
- Reset values: every output 0; state IDLE; buffer contents are don't-care.
- States: IDLE, START, WAIT_ON, WAIT_OFF, SETTLE, PRESS, GAP, VERIFY, WIN, FAIL.
- IDLE: on go, latch target_rounds (clamped) and inject_err, clear win/fail, set round=1, go to START.
- START: start=1 for exactly one cycle, then go to WAIT_ON with wr_idx=0.
- WAIT_ON: on leds!=0:
  - if leds is not one-hot, go to FAIL;
  - otherwise write leds to mem[wr_idx] in that same cycle and go to WAIT_OFF.
- WAIT_OFF: on leds==0, increment wr_idx.
  - If wr_idx+1==round, go to SETTLE.
  - Otherwise return to WAIT_ON.
  - A colour held for many cycles is captured once only.
- SETTLE: count cycles of leds==0. Any leds!=0 before SETTLE_CYCLES is reached goes to FAIL (the game showed more colours than expected). On reaching the count, rd_idx=0 and go to PRESS.
- PRESS: buttom=mem[rd_idx] for PRESS_CYCLES cycles.
  - If inject_err is armed, this is the final round and rd_idx==0, drive the colour rotated left by one bit instead (0001->0010, 1000->0001).
  - leds is ignored from SETTLE exit until VERIFY ends.
- GAP: buttom=0 for GAP_CYCLES cycles, then rd_idx++.
  - If rd_idx==round, go to VERIFY.
  - Otherwise go to PRESS.
- VERIFY: after VERIFY_CYCLES, compare score with round (score==round passes).
  - On pass with round==target, go to WIN (win=1).
  - On pass otherwise, round++ and go to WAIT_ON with wr_idx=0.
  - On mismatch, go to FAIL, except in an injected-error session where score==0 goes to WIN with fail=0 and win=1; that is the expected game-over result.
- WIN/FAIL: terminal; buttom=0. A later go restarts from IDLE semantics.
- go while busy is ignored.
- Overflow: round reaching MAX_SEQ+1 cannot happen because target is clamped; a write with wr_idx==MAX_SEQ goes to FAIL as a guard.
- Reset mid-session returns to IDLE immediately, with buttom=0 in the same cycle (asynchronous).
- All counters saturate at their limits and never wrap.

Decomposition:
- genius_pkg: state enum (autoplayer_state_t), a colour typedef (logic [3:0]), an is_onehot function and a rotl_color function.
- The game FSM shares genius_pkg.
- One sub-module, genius_seq_mem: MAX_SEQ x 4 register file, one synchronous write port and one combinational read port.

Test Plan:
- Autoplayer against genius_fsm (TIME=10), level 00, target_rounds=3: go -> one start pulse; captures 1, 2, 3 colours; score reads 1, 2, 3 at each VERIFY; win=1, fail=0, round=3, busy=0.
- Same setup with inject_err=1, target_rounds=2: round 1 passes; round 2 first press is the rotated colour; game resets score to 0; win=1, fail=0.
- Behavioural game model shows 3 colours in round 2 -> FAIL during SETTLE; fail=1, buttom=0.
- Model drives leds=0011 -> FAIL from WAIT_ON.
- Model holds leds=0100 for 50 cycles in round 1 -> exactly one capture; replay buttom=0100 for exactly 4 cycles, then 0 for 5 cycles.
- Assert rst_n low during PRESS -> buttom=0 asynchronously and all outputs 0. A go after release starts a fresh session with round=1. target_rounds=0 behaves as 1.
